aoc3_bank_reduce: RTL and testbench
===================================

Name: aoc3_bank_reduce

Overview:
- Downstream consumer of the 12-entry digit stack for AoC day 3, part 2.
- When a bank (input line) is finished, it walks the stack slots 0..MAX_CAP-1 through the stack's peek port and folds them into a decimal value (most-significant digit first).
- It adds that value to a running total, then pulses a clear so the stack is ready for the next bank.
- It sits between the stack and the top-level result/status registers.

Parameters:
- MAX_CAP, 12, number of stack slots read per bank; must match the stack instance.
- SUM_WIDTH, 64, width of the bank value and the running total.
- CNT_WIDTH, 16, width of the bank counter.

Ports:
- clock  in  1  system clock
- reset  in  1  asynchronous, active-high reset
- line_done  in  1  one-cycle pulse: the stack holds the final digits of the current bank
- input_end  in  1  one-cycle pulse: no further banks will arrive
- stack_data  in  `DATA_WIDTH  stack data_out; combinational function of peek_i
- peek_i  out  $clog2(MAX_CAP)+1  slot index driven to the stack
- stack_clear  out  1  one-cycle pulse, ORed into the stack's reset by the top level
- busy  out  1  high in any state other than IDLE and DONE
- bank_value  out  SUM_WIDTH  value of the last completed bank
- bank_valid  out  1  one-cycle pulse when bank_value updates
- total  out  SUM_WIDTH  running sum of all bank values
- bank_count  out  CNT_WIDTH  number of banks summed
- done  out  1  sticky; high after input_end has been processed
- err  out  1  sticky; bad digit seen or line_done overrun

Behaviour:
- Reset (asynchronous): all outputs go to 0; the state goes to IDLE; the accumulator and pending flags are cleared.
- Reset mid-operation aborts the bank with no partial update to total.
- States: IDLE, READ, ADD, CLEAR, DONE.

IDLE:
- peek_i = 0.
- line_done=1: clear the accumulator, set k=0, go to READ.
- input_end=1 with no line_done: go to DONE.
- Both pulses in the same cycle: process the bank first and latch end_pend.

READ (exactly MAX_CAP cycles):
- peek_i = k.
- Each cycle: acc <= acc*10 + d, with acc*10 computed as (acc<<3)+(acc<<1) at SUM_WIDTH.
- d = stack_data when stack_data <= 9.
- Otherwise d = 0 and err is set; this covers unfilled slots, which hold all-ones after stack reset.
- When k = MAX_CAP-1: go to ADD.

ADD (1 cycle):
- bank_value <= acc; bank_valid pulses in this cycle.
- total <= total + acc, wrapping modulo 2^SUM_WIDTH; no saturation.
- bank_count <= bank_count + 1, wrapping.
- Go to CLEAR.

CLEAR (1 cycle):
- stack_clear = 1.
- If end_pend is set, go to DONE; otherwise go to IDLE.

DONE:
- done = 1 and holds; busy = 0.
- All further line_done and input_end pulses are ignored.
- Leaves only on reset.

Timing and counters:
- Latency: line_done in cycle t gives READ in t+1..t+MAX_CAP, ADD with bank_valid in t+MAX_CAP+1, CLEAR in t+MAX_CAP+2, and readiness in IDLE at t+MAX_CAP+3.
- Throughput: one bank per MAX_CAP+3 cycles.
- k is $clog2(MAX_CAP)+1 bits and never exceeds MAX_CAP-1.

Boundary conditions:
- line_done while busy: ignored and err set; the current bank completes unaffected.
- input_end while busy: latched into end_pend and honoured after the current CLEAR.
- total and bank_value are updated only in ADD, so both stay stable while busy.
- A 12-digit value is below 10^12 < 2^40; with SUM_WIDTH=64 there is no per-bank overflow.

Test Plan:
- Bench models the stack as a preloaded 12-entry array read combinationally via peek_i.
- 1. Reset, then stack 9,8,7,6,5,4,3,2,1,1,1,1 with a line_done pulse -> bank_valid exactly 13 cycles later, bank_value=987654321111, total=987654321111, stack_clear one cycle after bank_valid.
- 2. Four banks 987654321111, 811111111119, 434234234278, 888911112111, each issued once busy falls -> bank_count=4, total=3121910778619; then input_end -> done=1 and busy=0 next cycle.
- 3. A slot holding all-ones (unfilled) at slot 11 with other slots 1 -> that digit is counted as 0, bank_value=111111111110, err=1.
- 4. Second line_done pulse during READ -> ignored, err=1, only one bank_valid, bank_count incremented by 1.
- 5. input_end in the same cycle as line_done -> bank processed, done asserted the cycle after CLEAR; a later line_done produces no bank_valid.
- 6. Reset asserted asynchronously mid-READ -> all outputs 0 immediately; total=0 and bank_count=0 after release; next bank sums correctly from zero.

Source files
------------

// File: rtl/aoc3_bank_reduce.sv
`default_nettype none
// ============================================================================
// Module   : aoc3_bank_reduce
// Brief    : Reads the digit stack at the end of each bank, folds the digits
//            into a decimal value (MSD first) and accumulates a running total.
// Revision : 1.0
// ============================================================================
module aoc3_bank_reduce #(
    parameter int MAX_CAP    = 12,
    parameter int SUM_WIDTH  = 64,
    parameter int CNT_WIDTH  = 16,
    parameter int DATA_WIDTH = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       line_done,
    input  logic                       input_end,
    input  logic [DATA_WIDTH-1:0]      stack_data,
    output logic [$clog2(MAX_CAP):0]   peek_i,
    output logic                       stack_clear,
    output logic                       busy,
    output logic [SUM_WIDTH-1:0]       bank_value,
    output logic                       bank_valid,
    output logic [SUM_WIDTH-1:0]       total,
    output logic [CNT_WIDTH-1:0]       bank_count,
    output logic                       done,
    output logic                       err
);

    localparam int KW = $clog2(MAX_CAP) + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_ADD   = 3'd2,
        S_CLEAR = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_state;
    logic [KW-1:0]         r_k;
    logic [SUM_WIDTH-1:0]  r_acc;
    logic                  r_end_pend;
    logic                  r_stack_clear;
    logic                  r_busy;
    logic [SUM_WIDTH-1:0]  r_bank_value;
    logic                  r_bank_valid;
    logic [SUM_WIDTH-1:0]  r_total;
    logic [CNT_WIDTH-1:0]  r_bank_count;
    logic                  r_done;
    logic                  r_err;

    logic                  w_bad;
    logic [SUM_WIDTH-1:0]  w_digit;
    logic [SUM_WIDTH-1:0]  w_acc_next;
    logic                  w_last;

    // Slots that were never written read back as all-ones; they count as 0.
    assign w_bad      = (stack_data > DATA_WIDTH'(9));
    assign w_digit    = w_bad ? '0 : SUM_WIDTH'(stack_data);
    assign w_acc_next = (r_acc << 3) + (r_acc << 1) + w_digit;
    assign w_last     = (r_k == KW'(MAX_CAP - 1));

    // The final digit is folded on the edge that enters ADD, so bank_value
    // and total are already updated while bank_valid is high.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state       <= S_IDLE;
            r_k           <= '0;
            r_acc         <= '0;
            r_end_pend    <= 1'b0;
            r_stack_clear <= 1'b0;
            r_busy        <= 1'b0;
            r_bank_value  <= '0;
            r_bank_valid  <= 1'b0;
            r_total       <= '0;
            r_bank_count  <= '0;
            r_done        <= 1'b0;
            r_err         <= 1'b0;
        end else begin
            r_bank_valid  <= 1'b0;
            r_stack_clear <= 1'b0;
            if (r_busy) begin
                if (line_done) r_err      <= 1'b1;
                if (input_end) r_end_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (line_done) begin
                        r_acc      <= '0;
                        r_k        <= '0;
                        r_busy     <= 1'b1;
                        r_end_pend <= input_end;
                        r_state    <= S_READ;
                    end else if (input_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end
                end
                S_READ: begin
                    r_acc <= w_acc_next;
                    if (w_bad) r_err <= 1'b1;
                    if (w_last) begin
                        r_k          <= '0;
                        r_bank_value <= w_acc_next;
                        r_total      <= r_total + w_acc_next;
                        r_bank_count <= r_bank_count + 1'b1;
                        r_bank_valid <= 1'b1;
                        r_state      <= S_ADD;
                    end else begin
                        r_k <= r_k + KW'(1);
                    end
                end
                S_ADD: begin
                    r_stack_clear <= 1'b1;
                    r_state       <= S_CLEAR;
                end
                S_CLEAR: begin
                    r_busy <= 1'b0;
                    if (r_end_pend || input_end) begin
                        r_done  <= 1'b1;
                        r_state <= S_DONE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_DONE: begin
                    r_state <= S_DONE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign peek_i      = r_k;
    assign stack_clear = r_stack_clear;
    assign busy        = r_busy;
    assign bank_value  = r_bank_value;
    assign bank_valid  = r_bank_valid;
    assign total       = r_total;
    assign bank_count  = r_bank_count;
    assign done        = r_done;
    assign err         = r_err;

endmodule
`default_nettype wire

// File: tb/tb_aoc3_bank_reduce.sv
`default_nettype none
// ============================================================================
// Module   : tb_aoc3_bank_reduce
// Brief    : Self-checking bench for aoc3_bank_reduce with a preloaded stack.
// Revision : 1.0
// ============================================================================
module tb_aoc3_bank_reduce;

    localparam int MAX_CAP = 12;
    localparam int SW      = 64;
    localparam int CW      = 16;
    localparam int DW      = 4;

    logic          clock = 1'b0;
    logic          reset;
    logic          line_done;
    logic          input_end;
    logic [DW-1:0] stack_data;
    logic [4:0]    peek_i;
    logic          stack_clear;
    logic          busy;
    logic [SW-1:0] bank_value;
    logic          bank_valid;
    logic [SW-1:0] total;
    logic [CW-1:0] bank_count;
    logic          done;
    logic          err;

    logic [DW-1:0] stk [16];

    aoc3_bank_reduce #(
        .MAX_CAP(MAX_CAP), .SUM_WIDTH(SW), .CNT_WIDTH(CW), .DATA_WIDTH(DW)
    ) dut (
        .clock(clock), .reset(reset), .line_done(line_done), .input_end(input_end),
        .stack_data(stack_data), .peek_i(peek_i), .stack_clear(stack_clear),
        .busy(busy), .bank_value(bank_value), .bank_valid(bank_valid),
        .total(total), .bank_count(bank_count), .done(done), .err(err)
    );

    assign stack_data = peek_i[4] ? '1 : stk[peek_i[3:0]];

    always #5 clock = ~clock;

    int            n_pass = 0;
    int            n_tot  = 0;
    logic [63:0]   m_total;
    logic [15:0]   m_count;
    logic          m_err;

    typedef struct {
        logic [47:0] dig;
        logic [63:0] val;
    } vec_t;
    vec_t tbl [4];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic timeout_fail(input string nm);
        n_tot++;
        $display("FAIL %s: timeout waiting for DUT", nm);
    endtask

    // Decimal value of 12 digits, slot 0 most significant; non-digits count 0.
    function automatic logic [63:0] ref_val(input logic [47:0] dg);
        longint unsigned v = 0;
        logic [3:0] d;
        for (int i = 0; i < MAX_CAP; i++) begin
            d = dg[47-4*i -: 4];
            v = v * 10 + ((d <= 4'd9) ? longint'(d) : 0);
        end
        return v;
    endfunction

    function automatic logic ref_bad(input logic [47:0] dg);
        logic b = 1'b0;
        for (int i = 0; i < MAX_CAP; i++)
            if (dg[47-4*i -: 4] > 4'd9) b = 1'b1;
        return b;
    endfunction

    task automatic load(input logic [47:0] dg);
        for (int i = 0; i < 16; i++)
            stk[i] = (i < MAX_CAP) ? dg[47-4*i -: 4] : 4'hF;
    endtask

    task automatic do_reset();
        @(posedge clock); #1 reset = 1'b1;
        @(posedge clock); #1 reset = 1'b0;
        m_total = 0; m_count = 0; m_err = 1'b0;
    endtask

    task automatic wait_idle();
        for (int c = 0; c < 100; c++) begin
            if (!busy) return;
            @(posedge clock); #1;
        end
        timeout_fail("wait_idle");
    endtask

    task automatic bank(input logic [47:0] dg, input logic [63:0] exp, input string nm);
        int lat = 0;
        wait_idle();
        load(dg);
        line_done = 1'b1;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            if (c == 1) line_done = 1'b0;
            if (bank_valid) begin lat = c; break; end
        end
        if (lat == 0) begin
            timeout_fail({nm, "/bank_valid"});
            return;
        end
        m_total = m_total + exp;
        m_count = m_count + 1;
        m_err   = m_err | ref_bad(dg);
        chk({nm, "/latency"}, 64'(lat), 64'd13);
        chk({nm, "/value"}, bank_value, exp);
        chk({nm, "/total"}, total, m_total);
        chk({nm, "/count"}, 64'(bank_count), 64'(m_count));
        chk({nm, "/err"}, 64'(err), 64'(m_err));
        @(posedge clock); #1;
        chk({nm, "/clear"}, 64'(stack_clear), 64'd1);
        chk({nm, "/valid_off"}, 64'(bank_valid), 64'd0);
    endtask

    initial begin
        logic [47:0] dg;
        int nv, vc, sc, dc;
        line_done = 1'b0; input_end = 1'b0; reset = 1'b1;
        load('1);
        tbl[0] = '{48'h987654321111, 64'd987654321111};
        tbl[1] = '{48'h811111111119, 64'd811111111119};
        tbl[2] = '{48'h434234234278, 64'd434234234278};
        tbl[3] = '{48'h888911112111, 64'd888911112111};

        // Reset state
        do_reset();
        chk("rst/busy", 64'(busy), 0);
        chk("rst/peek", 64'(peek_i), 0);
        chk("rst/total", total, 0);
        chk("rst/count", 64'(bank_count), 0);
        chk("rst/done", 64'(done), 0);
        chk("rst/err", 64'(err), 0);

        // Table-driven banks
        for (int i = 0; i < 4; i++) bank(tbl[i].dig, tbl[i].val, $sformatf("tbl%0d", i));
        chk("tbl/sum4", total, 64'd3121910778619);
        chk("tbl/count4", 64'(bank_count), 4);

        // input_end alone from IDLE, then ignored line_done
        wait_idle();
        input_end = 1'b1;
        @(posedge clock); #1 input_end = 1'b0;
        chk("end/done", 64'(done), 1);
        chk("end/busy", 64'(busy), 0);
        line_done = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1 line_done = 1'b0;
            if (bank_valid) nv++;
        end
        chk("end/no_valid", 64'(nv), 0);
        chk("end/count", 64'(bank_count), 4);

        // Randomized banks with occasional non-digit slots
        do_reset();
        for (int n = 0; n < 8; n++) begin
            for (int i = 0; i < MAX_CAP; i++)
                dg[47-4*i -: 4] = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15))
                                                               : 4'($urandom_range(0, 9));
            bank(dg, ref_val(dg), $sformatf("rand%0d", n));
        end

        // Unfilled slot at the end counts as 0 and flags err
        do_reset();
        bank(48'h11111111111F, 64'd111111111110, "unfilled");

        // Second line_done during READ is ignored
        do_reset();
        wait_idle();
        load(48'h123456789012);
        line_done = 1'b1;
        nv = 0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clock); #1;
            line_done = (c == 5);
            if (bank_valid) nv++;
        end
        chk("overrun/valids", 64'(nv), 1);
        chk("overrun/err", 64'(err), 1);
        chk("overrun/count", 64'(bank_count), 1);
        chk("overrun/value", bank_value, 64'd123456789012);

        // line_done and input_end in the same cycle
        do_reset();
        load(48'h555555555555);
        line_done = 1'b1; input_end = 1'b1;
        vc = 0; sc = 0; dc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(posedge clock); #1;
            if (c == 1) begin line_done = 1'b0; input_end = 1'b0; end
            if (bank_valid && vc == 0) vc = c;
            if (stack_clear && sc == 0) sc = c;
            if (done && dc == 0) dc = c;
        end
        chk("both/valid_cyc", 64'(vc), 13);
        chk("both/clear_cyc", 64'(sc), 14);
        chk("both/done_cyc", 64'(dc), 15);
        chk("both/value", bank_value, 64'd555555555555);
        chk("both/busy", 64'(busy), 0);
        line_done = 1'b1;
        nv = 0;
        for (int c = 0; c < 20; c++) begin
            @(posedge clock); #1 line_done = 1'b0;
            if (bank_valid) nv++;
        end
        chk("both/no_valid", 64'(nv), 0);
        chk("both/done_hold", 64'(done), 1);

        // Asynchronous reset in the middle of READ
        do_reset();
        bank(48'h999999999999, 64'd999999999999, "pre_abort");
        wait_idle();
        load(48'h222222222222);
        line_done = 1'b1;
        for (int c = 1; c <= 6; c++) begin
            @(posedge clock); #1;
            if (c == 1) line_done = 1'b0;
        end
        #3 reset = 1'b1;
        #1;
        chk("abort/busy", 64'(busy), 0);
        chk("abort/peek", 64'(peek_i), 0);
        chk("abort/total", total, 0);
        chk("abort/count", 64'(bank_count), 0);
        chk("abort/value", bank_value, 0);
        @(posedge clock); #1 reset = 1'b0;
        m_total = 0; m_count = 0; m_err = 1'b0;
        @(posedge clock); #1;
        chk("abort/total_rel", total, 0);
        bank(48'h314159265358, 64'd314159265358, "post_abort");

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
`default_nettype wire
